drum_event_queue: RTL and testbench

// - Buffers drum-hit events from the gesture/strike detector and issues them one at a time to the SPI slave TX stage.
// - Drives drum_trigger_valid/drum_code, which the SPI stage latches into its TX buffer as byte {4'h0, drum_code}.
// - Holds each issued event until the SPI stage reports the byte shifted out (tx_done) or a timeout expires.
// - Prevents back-to-back triggers from overwriting an unsent byte.

---
 rtl/drum_pkg.sv | 6 +
 rtl/drum_event_queue_fifo.sv | 44 ++++
 rtl/drum_event_queue.sv | 87 ++++++++
 tb/tb_drum_event_queue.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drum_pkg.sv
// drum_pkg: shared drum code type, idle code and queue FSM states
package drum_pkg;
    typedef logic [3:0] drum_code_t;
    localparam drum_code_t DRUM_IDLE = 4'h0;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} dq_state_t;
endpackage

// File: rtl/drum_event_queue_fifo.sv
// sync_fifo: flop-array FIFO with wrapping pointers and a head view of the oldest entry
module sync_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       din_i,
    output logic [WIDTH-1:0]       head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign full_o  = count_q == (AW+1)'(DEPTH);
    assign empty_o = count_q == '0;
    assign count_o = count_q;
    assign head_o  = mem_q[rd_q];
    assign count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    // storage write, pointer advance (power-of-two depth wraps naturally) and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) rd_q <= rd_q + 1'b1;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/drum_event_queue.sv
// drum_event_queue: queues drum hits and hands them one at a time to the SPI TX stage
module drum_event_queue import drum_pkg::*; #(
    parameter int DEPTH       = 8,
    parameter int TIMEOUT_CYC = 3000,
    parameter int GAP_CYC     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   hit_valid,
    input  logic [3:0]             hit_code,
    input  logic                   tx_done,
    input  logic                   clear_flags,
    output logic                   drum_trigger_valid,
    output logic [3:0]             drum_code,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   busy,
    output logic                   overflow,
    output logic                   timeout
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int GW = GAP_CYC > 0 ? $clog2(GAP_CYC + 1) : 1;
    dq_state_t  state_q, state_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    drum_code_t code_q, code_d, head;
    logic trig_q, trig_d, ovf_q, ovf_d, to_q, to_d;
    logic push_req, fifo_pop, fifo_full, fifo_empty, to_hit, gap_hit, wait_exit, ovf_set, to_set;
    sync_fifo #(.WIDTH(4), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_req),
        .pop_i   (fifo_pop),
        .din_i   (hit_code),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );
    assign push_req  = hit_valid && hit_code != DRUM_IDLE;
    assign fifo_pop  = state_q == ISSUE;
    assign to_hit    = state_q == WAIT_DONE && to_cnt_q == TW'(TIMEOUT_CYC - 1);
    assign gap_hit   = state_q == GAP && gap_cnt_q == GW'(GAP_CYC - 1);
    assign wait_exit = state_q == WAIT_DONE && (tx_done || to_hit);
    assign ovf_set   = push_req && fifo_full && !fifo_pop;
    assign to_set    = to_hit && !tx_done;
    // sequencing, counters, strobe and sticky flags (a set beats a same-cycle clear)
    always_comb begin
        case (state_q)
            IDLE:      state_d = fifo_empty ? IDLE : ISSUE;
            ISSUE:     state_d = WAIT_DONE;
            WAIT_DONE: state_d = wait_exit ? (GAP_CYC == 0 ? IDLE : GAP) : WAIT_DONE;
            GAP:       state_d = gap_hit ? IDLE : GAP;
            default:   state_d = IDLE;
        endcase
        to_cnt_d  = state_q == WAIT_DONE ? to_cnt_q + 1'b1 : '0;
        gap_cnt_d = state_q == GAP ? gap_cnt_q + 1'b1 : '0;
        trig_d    = state_d == ISSUE;
        code_d    = state_d == ISSUE ? head : code_q;
        ovf_d     = ovf_set ? 1'b1 : clear_flags ? 1'b0 : ovf_q;
        to_d      = to_set ? 1'b1 : clear_flags ? 1'b0 : to_q;
    end
    // state registers; reset discards the in-flight event and clears every output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            to_cnt_q  <= '0;
            gap_cnt_q <= '0;
            code_q    <= DRUM_IDLE;
            trig_q    <= 1'b0;
            ovf_q     <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            to_cnt_q  <= to_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            code_q    <= code_d;
            trig_q    <= trig_d;
            ovf_q     <= ovf_d;
            to_q      <= to_d;
        end
    end
    assign drum_trigger_valid = trig_q;
    assign drum_code          = code_q;
    assign busy               = state_q != IDLE;
    assign overflow           = ovf_q;
    assign timeout            = to_q;
endmodule

// File: tb/tb_drum_event_queue.sv
// tb_drum_event_queue: directed scenarios for the drum event queue
module tb_drum_event_queue;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       hit_valid = 1'b0, tx_done = 1'b0, clear_flags = 1'b0;
    logic [3:0] hit_code = 4'h0;
    logic       drum_trigger_valid, busy, overflow, timeout;
    logic [3:0] drum_code, fifo_count;
    int checks = 0, failures = 0;

    drum_event_queue #(.DEPTH(8), .TIMEOUT_CYC(3000), .GAP_CYC(4)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .hit_valid          (hit_valid),
        .hit_code           (hit_code),
        .tx_done            (tx_done),
        .clear_flags        (clear_flags),
        .drum_trigger_valid (drum_trigger_valid),
        .drum_code          (drum_code),
        .fifo_count         (fifo_count),
        .busy               (busy),
        .overflow           (overflow),
        .timeout            (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; hit_valid = 1'b0; hit_code = 4'h0; tx_done = 1'b0; clear_flags = 1'b0;
        repeat (2) tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic push(input logic [3:0] c);
        hit_valid = 1'b1; hit_code = c;
        tick;
        hit_valid = 1'b0; hit_code = 4'h0;
    endtask

    task automatic pulse_tx;
        tx_done = 1'b1;
        tick;
        tx_done = 1'b0;
    endtask

    task automatic wait_trig(input int limit, output int n);
        n = 0;
        while (!drum_trigger_valid && n < limit) begin
            tick;
            n++;
        end
    endtask

    task automatic test_reset_state;
        do_reset;
        checks++;
        if ({drum_trigger_valid, drum_code, fifo_count, busy, overflow, timeout} !== 12'h000) begin
            failures++;
            $display("FAIL reset_state: got trig=%b code=%0d count=%0d busy=%b ovf=%b to=%b expected all 0",
                     drum_trigger_valid, drum_code, fifo_count, busy, overflow, timeout);
        end
    endtask

    task automatic test_single_hit;
        push(4'd2);
        checks++;
        if (drum_trigger_valid !== 1'b0 || fifo_count !== 4'd1) begin
            failures++;
            $display("FAIL single_write: got trig=%b count=%0d expected trig=0 count=1", drum_trigger_valid, fifo_count);
        end
        tick;
        checks++;
        if (drum_trigger_valid !== 1'b1 || drum_code !== 4'd2 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_issue: got trig=%b code=%0d busy=%b expected trig=1 code=2 busy=1", drum_trigger_valid, drum_code, busy);
        end
        tick;
        checks++;
        if (drum_trigger_valid !== 1'b0 || drum_code !== 4'd2) begin
            failures++;
            $display("FAIL single_width: got trig=%b code=%0d expected trig=0 code=2", drum_trigger_valid, drum_code);
        end
        repeat (9) tick;
        pulse_tx;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL single_gap%0d: got busy=%b expected 1", i, busy);
            end
            tick;
        end
        checks++;
        if (busy !== 1'b0 || drum_trigger_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_idle: got busy=%b trig=%b expected 0 0", busy, drum_trigger_valid);
        end
    endtask

    task automatic test_burst;
        int peak = 0, n;
        logic seen = 1'b0;
        logic [3:0] c0 = 4'h0;
        hit_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            hit_code = 4'(k + 1);
            tick;
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
            if (drum_trigger_valid) begin seen = 1'b1; c0 = drum_code; end
        end
        hit_valid = 1'b0; hit_code = 4'h0;
        checks++;
        if (peak !== 2) begin
            failures++;
            $display("FAIL burst_peak: got %0d expected 2", peak);
        end
        checks++;
        if (seen !== 1'b1 || c0 !== 4'd1) begin
            failures++;
            $display("FAIL burst_first: got seen=%b code=%0d expected 1 1", seen, c0);
        end
        for (int p = 0; p < 3; p++) begin
            if (p > 0) begin
                wait_trig(3, n);
                checks++;
                if (drum_trigger_valid !== 1'b1 || drum_code !== 4'(p + 1)) begin
                    failures++;
                    $display("FAIL burst_issue%0d: got trig=%b code=%0d expected 1 %0d", p, drum_trigger_valid, drum_code, p + 1);
                end
            end
            repeat (3) tick;
            pulse_tx;
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (drum_trigger_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL burst_gap%0d_%0d: got trig=%b expected 0", p, i, drum_trigger_valid);
                end
                tick;
            end
        end
        checks++;
        if (busy !== 1'b0 || fifo_count !== 4'd0) begin
            failures++;
            $display("FAIL burst_drain: got busy=%b count=%0d expected 0 0", busy, fifo_count);
        end
    endtask

    task automatic test_ignored_inputs;
        push(4'd0);
        checks++;
        if (fifo_count !== 4'd0 || overflow !== 1'b0 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL code0: got count=%0d ovf=%b to=%b expected 0 0 0", fifo_count, overflow, timeout);
        end
        pulse_tx;
        tick;
        checks++;
        if (busy !== 1'b0 || drum_trigger_valid !== 1'b0) begin
            failures++;
            $display("FAIL tx_idle: got busy=%b trig=%b expected 0 0", busy, drum_trigger_valid);
        end
    endtask

    task automatic test_overflow;
        int n;
        do_reset;
        hit_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            hit_code = 4'(k + 1);
            tick;
        end
        hit_valid = 1'b0; hit_code = 4'h0;
        checks++;
        if (fifo_count !== 4'd8 || overflow !== 1'b1 || drum_code !== 4'd1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL overflow: got count=%0d ovf=%b code=%0d busy=%b expected 8 1 1 1", fifo_count, overflow, drum_code, busy);
        end
        clear_flags = 1'b1; tick; clear_flags = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear: got %b expected 0", overflow);
        end
        hit_valid = 1'b1; hit_code = 4'd11; clear_flags = 1'b1;
        tick;
        hit_valid = 1'b0; hit_code = 4'h0; clear_flags = 1'b0;
        checks++;
        if (overflow !== 1'b1 || fifo_count !== 4'd8) begin
            failures++;
            $display("FAIL set_beats_clear: got ovf=%b count=%0d expected 1 8", overflow, fifo_count);
        end
        clear_flags = 1'b1; tick; clear_flags = 1'b0;
        pulse_tx;
        wait_trig(10, n);
        checks++;
        if (drum_trigger_valid !== 1'b1 || drum_code !== 4'd2) begin
            failures++;
            $display("FAIL ovf_next_issue: got trig=%b code=%0d expected 1 2", drum_trigger_valid, drum_code);
        end
        push(4'd12);
        checks++;
        if (fifo_count !== 4'd8 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL full_push_pop: got count=%0d ovf=%b expected 8 0", fifo_count, overflow);
        end
    endtask

    task automatic test_timeout;
        int n;
        do_reset;
        push(4'd5);
        push(4'd6);
        checks++;
        if (drum_trigger_valid !== 1'b1 || drum_code !== 4'd5) begin
            failures++;
            $display("FAIL to_issue: got trig=%b code=%0d expected 1 5", drum_trigger_valid, drum_code);
        end
        n = 0;
        while (!timeout && n < 3100) begin
            tick;
            n++;
        end
        checks++;
        if (n < 3000 || n > 3001) begin
            failures++;
            $display("FAIL to_latency: got %0d cycles expected 3000..3001", n);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (drum_trigger_valid !== 1'b0) begin
                failures++;
                $display("FAIL to_gap%0d: got trig=%b expected 0", i, drum_trigger_valid);
            end
            tick;
        end
        wait_trig(3, n);
        checks++;
        if (drum_trigger_valid !== 1'b1 || drum_code !== 4'd6 || timeout !== 1'b1) begin
            failures++;
            $display("FAIL to_next: got trig=%b code=%0d to=%b expected 1 6 1", drum_trigger_valid, drum_code, timeout);
        end
        clear_flags = 1'b1; tick; clear_flags = 1'b0;
        checks++;
        if (timeout !== 1'b0) begin
            failures++;
            $display("FAIL to_clear: got %b expected 0", timeout);
        end
    endtask

    task automatic test_reset_midway;
        logic any = 1'b0;
        do_reset;
        hit_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            hit_code = 4'(k + 1);
            tick;
        end
        hit_valid = 1'b0; hit_code = 4'h0;
        checks++;
        if (fifo_count !== 4'd3 || busy !== 1'b1 || drum_trigger_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_setup: got count=%0d busy=%b trig=%b expected 3 1 0", fifo_count, busy, drum_trigger_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({drum_trigger_valid, drum_code, fifo_count, busy, overflow, timeout} !== 12'h000) begin
            failures++;
            $display("FAIL rst_async: got trig=%b code=%0d count=%0d busy=%b expected all 0",
                     drum_trigger_valid, drum_code, fifo_count, busy);
        end
        repeat (2) tick;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (drum_trigger_valid) any = 1'b1;
        end
        checks++;
        if (any !== 1'b0 || busy !== 1'b0 || fifo_count !== 4'd0) begin
            failures++;
            $display("FAIL rst_release: got pulse=%b busy=%b count=%0d expected 0 0 0", any, busy, fifo_count);
        end
    endtask

    initial begin
        test_reset_state;
        test_single_hit;
        test_burst;
        test_ignored_inputs;
        test_overflow;
        test_timeout;
        test_reset_midway;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
